// File: rtl/lock_key_loader.sv
// Serial key loader for a logic-locked netlist: shifts in one frame, optionally parity-checks it, then presents the key once.
// Parity checking, retry counting and lockout exist only when LOCK_KEY_LOADER_PARITY_EN is defined.
module lock_key_loader #(
    parameter int KEY_WIDTH = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_ser_valid,
    input  logic                 i_ser_data,
    output logic                 o_ser_ready,
    output logic [KEY_WIDTH-1:0] o_key_out,
    output logic                 o_key_valid,
    output logic                 o_busy,
    output logic                 o_err,
    output logic                 o_lockout
);

`ifdef LOCK_KEY_LOADER_PARITY_EN
    localparam int F  = KEY_WIDTH + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);
`else
    localparam int F  = KEY_WIDTH;
`endif
    localparam int BW = $clog2(F + 1);

    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_cfg
        $error("lock_key_loader: MAX_RETRY must be 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_LOADED,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t               r_state;
    logic [F-1:0]         r_shreg;
    logic [BW-1:0]        r_bit_cnt;
    logic [KEY_WIDTH-1:0] r_key;
`ifdef LOCK_KEY_LOADER_PARITY_EN
    logic [RW-1:0]        r_retry_cnt;
    logic                 r_err;
`endif

    logic         w_accept;
    logic         w_last;
    logic [F-1:0] w_bit_mask;

    assign w_accept   = (r_state == S_SHIFT) && i_ser_valid;
    assign w_last     = (r_bit_cnt == BW'(F - 1));
    assign w_bit_mask = F'(i_ser_data) << r_bit_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_key       <= '0;
`ifdef LOCK_KEY_LOADER_PARITY_EN
            r_retry_cnt <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_FAIL: begin
                    if (i_start) begin
                        r_state   <= S_SHIFT;
                        r_shreg   <= '0;
                        r_bit_cnt <= '0;
`ifdef LOCK_KEY_LOADER_PARITY_EN
                        r_err     <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    if (w_accept) begin
                        r_shreg   <= r_shreg | w_bit_mask;
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        if (w_last) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
`ifdef LOCK_KEY_LOADER_PARITY_EN
                    if (^r_shreg == 1'b0) begin
                        r_key   <= r_shreg[KEY_WIDTH-1:0];
                        r_state <= S_LOADED;
                    end else begin
                        r_err       <= 1'b1;
                        r_retry_cnt <= r_retry_cnt + RW'(1);
                        // Lockout is terminal, so the counter never wraps.
                        r_state     <= (r_retry_cnt == RW'(MAX_RETRY - 1)) ? S_LOCKOUT : S_FAIL;
                    end
`else
                    r_key   <= r_shreg[KEY_WIDTH-1:0];
                    r_state <= S_LOADED;
`endif
                end
                S_LOADED, S_LOCKOUT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ser_ready = (r_state == S_SHIFT);
    assign o_busy      = (r_state == S_SHIFT) || (r_state == S_CHECK);
    assign o_key_valid = (r_state == S_LOADED);
    // The key register is only exposed while the key is declared valid.
    assign o_key_out   = r_key & {KEY_WIDTH{o_key_valid}};
`ifdef LOCK_KEY_LOADER_PARITY_EN
    assign o_err       = r_err;
    assign o_lockout   = (r_state == S_LOCKOUT);
`else
    assign o_err       = 1'b0;
    assign o_lockout   = 1'b0;
`endif

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader; parity scenarios run when LOCK_KEY_LOADER_PARITY_EN is defined.
module tb_lock_key_loader;

    localparam int KW = 4;
`ifdef LOCK_KEY_LOADER_PARITY_EN
    localparam int F = KW + 1;
`else
    localparam int F = KW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ser_valid = 1'b0;
    logic          ser_data = 1'b0;
    logic          ser_ready;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic          err;
    logic          lockout;

    int n_chk = 0;
    int n_bad = 0;

    // Frames LSB first; bit 4 is the parity bit when parity is enabled.
    logic [7:0] fr_a   = 8'b0001_1101;
    logic [7:0] fr_b   = 8'b0001_0010;
    logic [7:0] fr_bad = 8'b0000_1101;

    lock_key_loader #(.KEY_WIDTH(KW), .MAX_RETRY(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_ser_valid (ser_valid),
        .i_ser_data  (ser_data),
        .o_ser_ready (ser_ready),
        .o_key_out   (key_out),
        .o_key_valid (key_valid),
        .o_busy      (busy),
        .o_err       (err),
        .o_lockout   (lockout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        ser_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ser_ready), 32'd0);
        chk("rst_key",   32'(key_out),   32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_lock",  32'(lockout),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Streams n bits; gappy uses valid pattern 1,0,0,1 and drives junk on idle cycles.
    task automatic send(input logic [7:0] frame, input int n, input bit gappy,
                        input bit chk_rdy, input logic rdy_exp);
        int  idx = 0;
        int  cyc = 0;
        logic v;
        logic [3:0] pat = 4'b1001;
        while (idx < n && cyc < 64) begin
            v         = gappy ? pat[cyc % 4] : 1'b1;
            ser_valid = v;
            ser_data  = v ? frame[idx] : ~frame[idx];
            if (chk_rdy) chk("ser_ready", 32'(ser_ready), 32'(rdy_exp));
            @(posedge clk);
            if (v) idx++;
            cyc++;
            #1;
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        if (cyc >= 64) chk("send_timeout", 32'(idx), 32'(n));
    endtask

    initial begin
        int cnt;
        do_reset();

        // Basic load and latency
        pulse_start();
        chk("ready_after_start", 32'(ser_ready), 32'd1);
        chk("busy_in_shift",     32'(busy),      32'd1);
        send(fr_a, F, 1'b0, 1'b1, 1'b1);
        chk("busy_in_check", 32'(busy),      32'd1);
        chk("valid_in_check", 32'(key_valid), 32'd0);
        cnt = F;
        while (!key_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency",  32'(cnt + 1),  32'(F + 2));
        chk("key_a",    32'(key_out),  32'hD);
        chk("err_a",    32'(err),      32'd0);
        chk("busy_done", 32'(busy),    32'd0);

        // LOADED ignores start and new bits
        pulse_start();
        chk("loaded_ready", 32'(ser_ready), 32'd0);
        send(8'h00, F, 1'b0, 1'b1, 1'b0);
        wait_cyc(2);
        chk("loaded_key",   32'(key_out),   32'hD);
        chk("loaded_valid", 32'(key_valid), 32'd1);

`ifdef LOCK_KEY_LOADER_PARITY_EN
        // Bad parity then good retry
        do_reset();
        pulse_start();
        send(fr_bad, F, 1'b0, 1'b0, 1'b0);
        wait_cyc(2);
        chk("bad_err",   32'(err),       32'd1);
        chk("bad_key",   32'(key_out),   32'd0);
        chk("bad_valid", 32'(key_valid), 32'd0);
        chk("bad_busy",  32'(busy),      32'd0);
        chk("bad_lock",  32'(lockout),   32'd0);
        pulse_start();
        chk("retry_err_clr", 32'(err),       32'd0);
        chk("retry_ready",   32'(ser_ready), 32'd1);
        send(fr_b, F, 1'b0, 1'b0, 1'b0);
        wait_cyc(2);
        chk("retry_key",   32'(key_out),   32'h2);
        chk("retry_valid", 32'(key_valid), 32'd1);

        // Three bad frames lock out
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            send(fr_bad, F, 1'b0, 1'b0, 1'b0);
            wait_cyc(2);
            chk($sformatf("lock_after_%0d", i + 1), 32'(lockout), 32'(i == 2));
        end
        pulse_start();
        send(fr_a, F, 1'b0, 1'b0, 1'b0);
        wait_cyc(2);
        chk("lock_valid", 32'(key_valid), 32'd0);
        chk("lock_key",   32'(key_out),   32'd0);
        chk("lock_hold",  32'(lockout),   32'd1);
        chk("lock_ready", 32'(ser_ready), 32'd0);
`else
        // Any frame loads without a parity check
        do_reset();
        pulse_start();
        send(8'h06, F, 1'b0, 1'b0, 1'b0);
        wait_cyc(2);
        chk("np_key",  32'(key_out), 32'h6);
        chk("np_err",  32'(err),     32'd0);
        chk("np_lock", 32'(lockout), 32'd0);
`endif

        // Gapped valid
        do_reset();
        pulse_start();
        send(fr_a, F, 1'b1, 1'b1, 1'b1);
        wait_cyc(2);
        chk("gap_key",   32'(key_out),   32'hD);
        chk("gap_valid", 32'(key_valid), 32'd1);

        // Reset mid-frame
        do_reset();
        pulse_start();
        send(fr_a, 3, 1'b0, 1'b0, 1'b0);
        chk("mid_ready_pre", 32'(ser_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(ser_ready), 32'd0);
        chk("mid_busy",  32'(busy),      32'd0);
        chk("mid_valid", 32'(key_valid), 32'd0);
        chk("mid_key",   32'(key_out),   32'd0);
        chk("mid_err",   32'(err),       32'd0);
        chk("mid_lock",  32'(lockout),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send(fr_b, F, 1'b0, 1'b0, 1'b0);
        wait_cyc(2);
        chk("mid_new_key",   32'(key_out),   32'h2);
        chk("mid_new_valid", 32'(key_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_key_loader.md
# lock_key_loader

Loads the secret key for a logic-locked benchmark netlist from a serial secure-storage interface and drives it onto the netlist's `keyinput` bus. The block sits directly upstream of the locked circuit. It shifts in one key frame and checks parity. It presents the key only after a complete, valid frame, and then holds it stable. Partial or corrupt keys never reach the locked netlist, and repeated bad frames cause a permanent lockout.

## Interface
- `KEY_WIDTH`, default 4: number of key bits; the locked netlist's `keyinput[KEY_WIDTH-1:0]`.
- `MAX_RETRY`, default 3: number of bad frames tolerated before permanent lockout; must be 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that requests a key load.
- `ser_valid` in 1: serial bit qualifier from the storage interface.
- `ser_data` in 1: serial key bit, key bit 0 first.
- `ser_ready` out 1: the block accepts a bit on any cycle where `ser_valid && ser_ready`.
- `key_out` out KEY_WIDTH: key to the locked netlist; all-zero unless `key_valid`=1.
- `key_valid` out 1: key is loaded and stable.
- `busy` out 1: a frame is in progress.
- `err` out 1: the last frame failed parity; sticky until the next `start`.
- `lockout` out 1: `MAX_RETRY` bad frames have been received; cleared only by reset.

## Operation
- States:
  - IDLE: wait for `start`.
  - SHIFT: accept frame bits.
  - CHECK: evaluate parity.
  - LOADED: key presented.
  - FAIL: bad frame, waiting for a retry.
  - LOCKOUT: permanent, cleared only by reset.
- IDLE → SHIFT on `start`. In SHIFT, `bit_cnt` and the shift register clear, and `err` clears.
- SHIFT:
  - `ser_ready`=1.
  - Each handshake writes `ser_data` into `shreg[bit_cnt]` and increments `bit_cnt`.
  - The frame length is F = KEY_WIDTH+1 bits, the last bit being the parity bit.
  - When the F-th bit is accepted, go to CHECK.
  - `ser_valid` low stalls the frame indefinitely with no timeout.
- CHECK (one cycle):
  - Compute the XOR of all F bits.
  - If the result is 0 (even parity), go to LOADED: `key_reg`←`shreg[KEY_WIDTH-1:0]`.
  - Otherwise go to FAIL, increment `retry_cnt` and set `err`.
  - If `retry_cnt` reaches `MAX_RETRY`, go to LOCKOUT instead of FAIL.
- LOADED:
  - `key_valid`=1 and `key_out`=`key_reg`.
  - `start`, `ser_valid` and `ser_data` are ignored; the key is one-time programmable per reset.
- FAIL: `start` → SHIFT, beginning a new frame with `retry_cnt` retained.
- LOCKOUT: `lockout`=1, `key_out`=0, all inputs ignored.
- `start` during SHIFT or CHECK is ignored; an in-flight frame is never restarted.
- `retry_cnt` is $clog2(MAX_RETRY+1) bits wide. It never wraps, because LOCKOUT is terminal.
- `key_out` is gated with `key_valid` by an AND. This gating is a security requirement: the shift register contents are never visible on `key_out`.

## Timing
- Reset values:
  - state=IDLE.
  - `ser_ready`=0, `key_out`=0, `key_valid`=0, `busy`=0, `err`=0, `lockout`=0.
  - `shreg`=0, `bit_cnt`=0, `retry_cnt`=0.
- Reset is asynchronous assert and synchronous deassert in the system. Reset mid-frame discards all partial data immediately.
- `start` sampled in cycle t gives `ser_ready`=1 in cycle t+1.
- The last bit is accepted in cycle t. CHECK occupies t+1. `key_valid`, `err` or `lockout` rises in cycle t+2.
- Minimum load latency with `ser_valid` held high is F+2 cycles after the `start` sample.
- `busy`=1 in SHIFT and CHECK.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

## Configuration
- `LOCK_KEY_LOADER_PARITY_EN` defined:
  - Frame is KEY_WIDTH+1 bits with the parity check as above.
  - `err`, `lockout` and retry counting are active.
- Not defined:
  - Frame is KEY_WIDTH bits.
  - CHECK always goes to LOADED.
  - `err` and `lockout` are tied to 0, and the retry logic is removed.

## Test plan
- Reset, then `start` followed by frame bits 1,0,1,1 plus parity 1 with `ser_valid` held high. Required: `key_out`=4'b1101, `key_valid` high 7 cycles after the `start` sample, `err`=0.
- Same frame with parity 0. Required: `err`=1, `key_out`=0, state FAIL. A second `start` with a good frame 0,1,0,0 plus parity 1 gives `key_out`=4'b0010.
- Three consecutive bad frames. Required: `lockout`=1 after the third. A fourth `start` with a good frame leaves `key_valid`=0 and `key_out`=0.
- `ser_valid` toggling 1,0,0,1,… during SHIFT. Required: only qualified bits are captured, `key_out` is correct, and `ser_ready` stays high throughout SHIFT.
- `rst_n` pulsed low after 3 bits, then a fresh full frame. Required: all outputs are 0 immediately at assertion, and the new key is loaded correctly.
- In LOADED, apply `start` and a new bit stream. Required: `key_out` is unchanged and `ser_ready` stays 0.
